// File: rtl/minv_pkg.sv
// Shared sizing and state encoding for the modular-inverse operand load/unload registers.
package minv_pkg;
    localparam int DW = 256;
    localparam int WW = 16;
    localparam int NW = DW / WW;
    localparam int IW = $clog2(NW);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;
endpackage

// File: rtl/minv_rot_reg.sv
// Wide result register: sync clear, parallel load, cyclic right-rotate by one word.
module minv_rot_reg #(
    parameter int DW = 256,
    parameter int WW = 16
) (
    input  logic          clk,
    input  logic          clr_i,
    input  logic          ld_i,
    input  logic          rot_i,
    input  logic [DW-1:0] d_i,
    output logic [WW-1:0] word_o
);
    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;

    // Rotating (not shifting) leaves the captured value intact after a full pass.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (ld_i) begin
            q_d = d_i;
        end else if (rot_i) begin
            q_d = {q_q[WW-1:0], q_q[DW-1:WW]};
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign word_o = q_q[WW-1:0];
endmodule

// File: rtl/minv_reg_unload_t.sv
// Parallel-in / word-serial-out unload register: captures a 256-bit result and
// streams it LSW first over a valid/ready handshake.
module minv_reg_unload_t
    import minv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] din,
    output logic [WW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [IW-1:0] word_idx,
    output logic          busy,
    output logic          done
);
    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_q, done_d;
    logic          ld;
    logic          rot;
    logic          xfer;

    assign xfer = (state_q == SEND) && dout_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        ld      = 1'b0;
        rot     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    ld      = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // load is deliberately ignored here; the stream in flight completes.
                if (xfer) begin
                    rot = 1'b1;
                    if (idx_q == IW'(NW - 1)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    minv_rot_reg #(
        .DW(DW),
        .WW(WW)
    ) u_rot (
        .clk   (clk),
        .clr_i (rst),
        .ld_i  (ld),
        .rot_i (rot),
        .d_i   (din),
        .word_o(dout)
    );

    assign dout_valid = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign word_idx   = idx_q;
    assign done       = done_q;
endmodule

// File: tb/tb_minv_reg_unload_t.sv
// Bench for minv_reg_unload_t: directed table/sequences plus randomized queue-model run.
module tb_minv_reg_unload_t;
    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [255:0] din;
    logic [15:0]  dout;
    logic         dout_valid;
    logic         dout_ready;
    logic [3:0]   word_idx;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    minv_reg_unload_t dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .din       (din),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .word_idx  (word_idx),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic        ready;
        logic [15:0] dout;
        logic [3:0]  idx;
        logic        valid;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    logic [255:0] d1;
    logic [255:0] d2;
    logic [255:0] a5;
    logic [255:0] cur_din;
    logic [255:0] asm_v;
    logic [15:0]  wq[$];
    logic         done_exp;
    int           k;
    int           c;
    int           xfers;
    int           widx;

    initial begin
        rst = 1'b1; load = 1'b0; din = '0; dout_ready = 1'b0;
        for (int i = 0; i < 16; i++) d1[i*16 +: 16] = 16'(i);
        a5 = {16{16'hA5A5}};
        for (int i = 0; i < 16; i++)
            tbl[i] = '{ready: 1'b1, dout: 16'(i), idx: 4'(i), valid: 1'b1, busy: 1'b1, done: 1'b0};
        tbl[16] = '{ready: 1'b1, dout: 16'h0000, idx: 4'd0, valid: 1'b0, busy: 1'b0, done: 1'b1};
        tbl[17] = '{ready: 1'b1, dout: 16'h0000, idx: 4'd0, valid: 1'b0, busy: 1'b0, done: 1'b0};

        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", 256'(dout_valid), 256'(0));
        chk("rst_busy",  256'(busy), 256'(0));
        chk("rst_done",  256'(done), 256'(0));
        chk("rst_dout",  256'(dout), 256'(0));
        chk("rst_idx",   256'(word_idx), 256'(0));

        // Test 1: ready held high, word k = k
        din = d1; load = 1'b1; dout_ready = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 18; i++) begin
            dout_ready = tbl[i].ready;
            chk($sformatf("t1_dout[%0d]", i),  256'(dout), 256'(tbl[i].dout));
            chk($sformatf("t1_idx[%0d]", i),   256'(word_idx), 256'(tbl[i].idx));
            chk($sformatf("t1_valid[%0d]", i), 256'(dout_valid), 256'(tbl[i].valid));
            chk($sformatf("t1_busy[%0d]", i),  256'(busy), 256'(tbl[i].busy));
            chk($sformatf("t1_done[%0d]", i),  256'(done), 256'(tbl[i].done));
            tick();
        end

        // Test 2: ready pattern 1,0,0 repeating
        din = d1; load = 1'b1;
        tick();
        load = 1'b0;
        k = 0; c = 0;
        while (k < 16 && c < 100) begin
            chk("t2_valid", 256'(dout_valid), 256'(1));
            chk("t2_dout",  256'(dout), 256'(k));
            chk("t2_idx",   256'(word_idx), 256'(k));
            chk("t2_done",  256'(done), 256'(0));
            dout_ready = (c % 3 == 0);
            tick();
            if (dout_ready) k++;
            c++;
        end
        chk("t2_words", 256'(k), 256'(16));
        chk("t2_done_end", 256'(done), 256'(1));
        chk("t2_busy_end", 256'(busy), 256'(0));
        dout_ready = 1'b1;
        tick();

        // Test 3: load while busy is ignored
        din = d1; load = 1'b1;
        tick();
        load = 1'b0;
        for (int j = 0; j < 16; j++) begin
            chk("t3_dout", 256'(dout), 256'(j));
            chk("t3_idx",  256'(word_idx), 256'(j));
            load = (j == 5);
            if (j == 5) din = '1;
            tick();
        end
        load = 1'b0;
        chk("t3_done", 256'(done), 256'(1));
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("t3_idle_valid", 256'(dout_valid), 256'(0));
            chk("t3_idle_done",  256'(done), 256'(0));
        end

        // Test 4: reset mid-stream
        din = d1; load = 1'b1;
        tick();
        load = 1'b0;
        for (int j = 0; j < 7; j++) tick();
        chk("t4_idx7", 256'(word_idx), 256'(7));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_valid", 256'(dout_valid), 256'(0));
        chk("t4_busy",  256'(busy), 256'(0));
        chk("t4_dout",  256'(dout), 256'(0));
        chk("t4_idx",   256'(word_idx), 256'(0));
        for (int j = 0; j < 20; j++) begin
            chk("t4_nodone", 256'(done), 256'(0));
            tick();
        end
        d2 = rand256();
        din = d2; load = 1'b1;
        tick();
        load = 1'b0;
        chk("t4_w0", 256'(dout), 256'(d2[15:0]));
        chk("t4_i0", 256'(word_idx), 256'(0));
        tick();
        chk("t4_w1", 256'(dout), 256'(d2[31:16]));
        chk("t4_i1", 256'(word_idx), 256'(1));
        for (int j = 0; j < 40 && !done; j++) tick();
        chk("t4_done", 256'(done), 256'(1));
        tick();

        // Test 5: load in the done cycle
        din = d1; load = 1'b1;
        tick();
        load = 1'b0;
        for (int j = 0; j < 15; j++) tick();
        chk("t5_valid15", 256'(dout_valid), 256'(1));
        chk("t5_idx15",   256'(word_idx), 256'(15));
        tick();
        chk("t5_done",    256'(done), 256'(1));
        chk("t5_gap",     256'(dout_valid), 256'(0));
        din = a5; load = 1'b1;
        tick();
        load = 1'b0;
        chk("t5_valid2", 256'(dout_valid), 256'(1));
        chk("t5_dout2",  256'(dout), 256'(16'hA5A5));
        chk("t5_idx2",   256'(word_idx), 256'(0));
        chk("t5_done2",  256'(done), 256'(0));
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Test 6: random din/ready against a word-queue model
        done_exp = 1'b0; xfers = 0; cur_din = '0; asm_v = '0;
        for (int cyc = 0; cyc < 80000 && xfers < 1000; cyc++) begin
            chk("t6_valid", 256'(dout_valid), 256'(wq.size() != 0));
            chk("t6_busy",  256'(busy), 256'(wq.size() != 0));
            chk("t6_done",  256'(done), 256'(done_exp));
            if (wq.size() != 0) begin
                chk("t6_dout", 256'(dout), 256'(wq[0]));
                chk("t6_idx",  256'(word_idx), 256'(16 - wq.size()));
            end
            if (done_exp) chk("t6_reg", dut.u_rot.q_q, cur_din);
            dout_ready = ($urandom_range(3, 0) != 0);
            load = (wq.size() == 0) ? ($urandom_range(1, 0) == 1) : ($urandom_range(9, 0) == 0);
            din = rand256();
            done_exp = 1'b0;
            if (wq.size() != 0) begin
                if (dout_ready) begin
                    widx = 16 - wq.size();
                    asm_v[widx*16 +: 16] = wq.pop_front();
                    if (wq.size() == 0) begin
                        done_exp = 1'b1;
                        xfers++;
                        chk("t6_asm", asm_v, cur_din);
                    end
                end
            end else if (load) begin
                cur_din = din;
                asm_v = '0;
                for (int i = 0; i < 16; i++) wq.push_back(din[i*16 +: 16]);
            end
            tick();
        end
        load = 1'b0;
        chk("t6_count", 256'(xfers), 256'(1000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
